// File: rtl/transport_pkg.sv
// Shared definitions for the transport framing logic.
//   K_IDLE / K_SOF / K_EOF / K_ABT : control (comma) codes on the byte lane
//   state_t                        : framing FSM states
//   make_header()                  : header byte carrying the granted source index
package transport_pkg;

  localparam logic [7:0] K_IDLE = 8'h7C;
  localparam logic [7:0] K_SOF  = 8'hFC;
  localparam logic [7:0] K_EOF  = 8'hFD;
  localparam logic [7:0] K_ABT  = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_HDR,
    ST_PAYLOAD,
    ST_EOF,
    ST_ABORT
  } state_t;

  // Header layout: upper bits reserved as zero, low 3 bits = source index.
  localparam int HDR_PAD_W = 5;

  function automatic logic [7:0] make_header(input logic [2:0] id);
    return {{HDR_PAD_W{1'b0}}, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : index with highest priority this round
//   grant     : one-hot grant (all zero when nothing requests)
//   grant_idx : index of the granted requester
//   grant_any : at least one request present
// The search starts at ptr and wraps, so the caller rotates ptr to get fairness.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!grant_any && req[j]) begin
        grant_any = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/transport_scheduler.sv
// Round-robin scheduler framing packets from N_SRC sources onto one byte lane.
//   clk, rst        : clock, synchronous active-high reset
//   src_valid/data/last, src_ready : per-source byte streams (source i at data[8i+7:8i])
//   tx_data, tx_comma : transmitted byte; tx_comma=1 marks a control code
//   byte_cnt        : payload bytes sent in the current/last frame
//   grant_id        : source currently (or most recently) granted
//   busy            : high from SOF through EOF/ABT
//   err_abort       : one-cycle pulse alongside K_ABT
// All outputs are registered: what a state emits appears on the lane one cycle later.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | lane idles; pick next source round-robin from rr_ptr
// SOF      | emit K_SOF, clear byte_cnt
// HDR      | emit header byte with source index
// PAYLOAD  | forward granted source bytes; stuff K_IDLE on stalls
// EOF      | emit K_EOF, advance rr_ptr past the granted source
// ABORT    | emit K_ABT + err_abort, advance rr_ptr
module transport_scheduler
  import transport_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int MAX_LEN   = 256,
  parameter int STALL_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     src_valid,
  input  logic [8*N_SRC-1:0]   src_data,
  input  logic [N_SRC-1:0]     src_last,
  output logic [N_SRC-1:0]     src_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_comma,
  output logic [31:0]          byte_cnt,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 err_abort
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int SW = $clog2(STALL_MAX + 1);

  state_t             state, state_nxt;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      gnt_idx;
  logic [N_SRC-1:0]   gnt_onehot;
  logic [SW-1:0]      stall_cnt;

  logic [N_SRC-1:0]   arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  logic               sel_valid;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic               accept;
  logic               stall_hit;
  logic               len_hit;

  logic [7:0]         tx_data_d;
  logic               tx_comma_d;
  logic [31:0]        byte_cnt_d;
  logic               busy_d;
  logic               err_d;
  logic [N_SRC-1:0]   ready_d;

  rr_arbiter #(.N(N_SRC), .IW(IW)) u_arb (
    .req       (src_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  assign sel_valid = src_valid[gnt_idx];
  assign sel_data  = src_data[int'(gnt_idx)*8 +: 8];
  assign sel_last  = src_last[gnt_idx];
  assign accept    = (state == ST_PAYLOAD) && sel_valid && src_ready[gnt_idx];
  assign stall_hit = (state == ST_PAYLOAD) && !sel_valid && (stall_cnt == SW'(STALL_MAX - 1));
  // A last byte that lands exactly on MAX_LEN is a normal end, so only non-last bytes trip this.
  assign len_hit   = accept && !sel_last && (byte_cnt + 32'd1 == 32'(MAX_LEN));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (arb_any) state_nxt = ST_SOF;
      ST_SOF:     state_nxt = ST_HDR;
      ST_HDR:     state_nxt = ST_PAYLOAD;
      ST_PAYLOAD: begin
        if (accept) begin
          if (sel_last)     state_nxt = ST_EOF;
          else if (len_hit) state_nxt = ST_ABORT;
        end else if (stall_hit) begin
          state_nxt = ST_ABORT;
        end
      end
      ST_EOF:     state_nxt = ST_IDLE;
      ST_ABORT:   state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output logic (values registered below)
  always_comb begin
    tx_data_d  = K_IDLE;
    tx_comma_d = 1'b1;
    byte_cnt_d = byte_cnt;
    busy_d     = 1'b0;
    err_d      = 1'b0;
    // Ready follows the state being entered so it is already up in the first PAYLOAD cycle.
    ready_d    = (state_nxt == ST_PAYLOAD) ? gnt_onehot : '0;
    case (state)
      ST_SOF: begin
        tx_data_d  = K_SOF;
        busy_d     = 1'b1;
        byte_cnt_d = '0;
      end
      ST_HDR: begin
        tx_data_d  = make_header(grant_id);
        tx_comma_d = 1'b0;
        busy_d     = 1'b1;
      end
      ST_PAYLOAD: begin
        busy_d = 1'b1;
        if (accept) begin
          tx_data_d  = sel_data;
          tx_comma_d = 1'b0;
          byte_cnt_d = byte_cnt + 32'd1;
        end
      end
      ST_EOF: begin
        tx_data_d = K_EOF;
        busy_d    = 1'b1;
      end
      ST_ABORT: begin
        tx_data_d = K_ABT;
        busy_d    = 1'b1;
        err_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data   <= K_IDLE;
      tx_comma  <= 1'b1;
      byte_cnt  <= '0;
      busy      <= 1'b0;
      err_abort <= 1'b0;
      src_ready <= '0;
    end else begin
      tx_data   <= tx_data_d;
      tx_comma  <= tx_comma_d;
      byte_cnt  <= byte_cnt_d;
      busy      <= busy_d;
      err_abort <= err_d;
      src_ready <= ready_d;
    end
  end

  // Grant, round-robin pointer and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      rr_ptr     <= '0;
      stall_cnt  <= '0;
    end else begin
      if (state == ST_IDLE && arb_any) begin
        gnt_idx    <= arb_idx;
        gnt_onehot <= arb_grant;
      end
      if (state == ST_EOF || state == ST_ABORT)
        rr_ptr <= (gnt_idx == IW'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
      if (state != ST_PAYLOAD || accept) stall_cnt <= '0;
      else if (!sel_valid)               stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign grant_id = 3'(gnt_idx);

endmodule
